// File: rtl/uart_rx_framed_if.sv
// Receive-side bundle: serial line in, byte strobe and error strobes out.
// Latency: none (wires only).
// Backpressure: none; the consumer samples the one-cycle strobes as they fire.
interface uart_rx_framed_if;
  logic       i_uart_rx;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_break;

  // Driver of the line / consumer of received bytes.
  modport master (
    output i_uart_rx,
    input  o_wr,
    input  o_data,
    input  o_frame_err,
    input  o_break
  );

  // The receiver itself.
  modport slave (
    input  i_uart_rx,
    output o_wr,
    output o_data,
    output o_frame_err,
    output o_break
  );
endinterface

// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver with framing-error and line-break reporting.
// Latency: strobes fire 1 cycle after the stop-bit sample (line to rx_s adds 2 cycles).
// Backpressure: none; o_wr/o_frame_err/o_break are single-cycle, o_data holds until next o_wr.
module uart_rx_framed #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_rx_framed_if.slave rx_if
);

  // Half-bit delay puts every later sample in the middle of its bit.
  localparam logic [23:0] HALF_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_M1 = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t      state_q,     state_d;
  logic [1:0]  sync_q,      sync_d;
  logic [23:0] baud_cnt_q,  baud_cnt_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  data_q,      data_d;
  logic        wr_q,        wr_d;
  logic        frame_err_q, frame_err_d;
  logic        break_q,     break_d;

  logic rx_s;
  logic cnt_zero;

  assign rx_s     = sync_q[1];
  assign cnt_zero = (baud_cnt_q == 24'd0);

  assign rx_if.o_wr        = wr_q;
  assign rx_if.o_data      = data_q;
  assign rx_if.o_frame_err = frame_err_q;
  assign rx_if.o_break     = break_q;

  // State register; reset aborts any frame in flight and suppresses its strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      sync_q      <= 2'b11;
      baud_cnt_q  <= 24'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
    end
  end

  // Next-state: synchronizer shift, bit timing, frame decode and strobe generation.
  always_comb begin
    sync_d      = {sync_q[0], rx_if.i_uart_rx};
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    frame_err_d = 1'b0;
    break_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          baud_cnt_d = HALF_M1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (cnt_zero) begin
          if (rx_s) begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = ST_IDLE;
          end else begin
            baud_cnt_d = FULL_M1;
            bit_cnt_d  = 3'd0;
            state_d    = ST_DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 24'd1;
        end
      end

      ST_DATA: begin
        if (cnt_zero) begin
          // Shift in at the MSB so bit 0 ends up in the LSB after 8 shifts.
          shift_d    = {rx_s, shift_q[7:1]};
          baud_cnt_d = FULL_M1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 24'd1;
        end
      end

      ST_STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
            data_d  = shift_q;
            wr_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // Bad stop: keep the last good byte, and wait for the line to
            // recover so a held-low line reports only once.
            frame_err_d = 1'b1;
            break_d     = (shift_q == 8'h00);
            state_d     = ST_WAIT_HIGH;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 24'd1;
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: directed scenarios plus random frames vs. an event model.
// Latency: expected strobe 3 + CPB/2 + 9*CPB cycles after the start edge is driven.
// Backpressure: none; every strobe is captured by a negedge monitor.
module tb_uart_rx_framed;

  localparam int CPB = 16;

  typedef struct {
    int         cyc;
    logic       wr;
    logic       fe;
    logic       brk;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;
  logic [7:0] last_good;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  uart_rx_framed_if bus ();

  uart_rx_framed #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .rx_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: during the cycle after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe cycle with the byte visible at that moment.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (bus.o_wr || bus.o_frame_err || bus.o_break)) begin
      e.cyc  = cyc;
      e.wr   = bus.o_wr;
      e.fe   = bus.o_frame_err;
      e.brk  = bus.o_break;
      e.data = bus.o_data;
      obs_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_uart_rx = 1'b1;
    repeat (n) tick();
  endtask

  // Bit boundary i for a transmitter running pct percent slower than nominal.
  function automatic int bnd(input int i, input int pct);
    return (i * CPB * (100 + pct)) / 100;
  endfunction

  // Model: a frame whose start edge is driven at cycle k yields exactly one
  // event at k + 2 (sync) + CPB/2 + 9*CPB + 1 (register).
  function automatic int ev_cyc(input int k);
    return k + 3 + CPB / 2 + 9 * CPB;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int pct,
                            input int abort_bit);
    logic [9:0] bits;
    int k;
    ev_t e;
    bits = {stop_ok, b, 1'b0};
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == abort_bit) begin
        rst = 1'b1;
        bus.i_uart_rx = 1'b1;
        tick();
        rst = 1'b0;
        last_good = 8'h00;
        return;
      end
      bus.i_uart_rx = bits[i];
      repeat (bnd(i + 1, pct) - bnd(i, pct)) tick();
    end
    e.cyc  = ev_cyc(k);
    e.wr   = stop_ok;
    e.fe   = !stop_ok;
    e.brk  = !stop_ok && (b == 8'h00);
    e.data = stop_ok ? b : last_good;
    if (stop_ok) last_good = b;
    exp_q.push_back(e);
  endtask

  initial begin
    ev_t e;
    int  k;
    int  n;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    last_good = 8'h00;
    rst = 1'b1;
    bus.i_uart_rx = 1'b1;
    repeat (5) tick();
    chk("rst_wr",   32'(bus.o_wr),        32'd0);
    chk("rst_fe",   32'(bus.o_frame_err), 32'd0);
    chk("rst_brk",  32'(bus.o_break),     32'd0);
    chk("rst_data", 32'(bus.o_data),      32'd0);
    rst = 1'b0;
    idle(10);

    // Single byte.
    send_frame(8'h55, 1'b1, 0, -1);
    idle(20);
    // Back-to-back, zero idle.
    send_frame(8'h00, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    idle(20);
    // Glitch shorter than half a bit, then a real byte.
    bus.i_uart_rx = 1'b0;
    repeat (4) tick();
    idle(30);
    send_frame(8'hA5, 1'b1, 0, -1);
    idle(20);
    // Framing error with non-zero data.
    send_frame(8'hA5, 1'b0, 0, -1);
    idle(40);
    // Break: 20 bit times low, one report, then a normal byte.
    k = cyc;
    bus.i_uart_rx = 1'b0;
    repeat (20 * CPB) tick();
    e.cyc = ev_cyc(k);
    e.wr = 1'b0;
    e.fe = 1'b1;
    e.brk = 1'b1;
    e.data = last_good;
    exp_q.push_back(e);
    idle(20);
    send_frame(8'h3C, 1'b1, 0, -1);
    idle(20);
    // Reset during data bit 4 of 0x81, then 0x81 again.
    send_frame(8'h81, 1'b1, 0, 5);
    chk("midrst_wr",   32'(bus.o_wr),        32'd0);
    chk("midrst_fe",   32'(bus.o_frame_err), 32'd0);
    chk("midrst_brk",  32'(bus.o_break),     32'd0);
    chk("midrst_data", 32'(bus.o_data),      32'd0);
    idle(12 * CPB);
    send_frame(8'h81, 1'b1, 0, -1);
    idle(20);

    // Random frames with +/-3% baud mismatch and random idle gaps.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit ok;
      int pct;
      b = 8'($urandom_range(0, 255));
      if (i % 8 == 3) b = 8'h00;
      ok = ($urandom_range(0, 4) != 0);
      pct = 3 * (int'($urandom_range(0, 2)) - 1);
      send_frame(b, ok, pct, -1);
      if (ok) idle($urandom_range(0, 40));
      else    idle($urandom_range(2 * CPB + 2, 4 * CPB));
    end
    idle(200);

    chk("n_events", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("ev%0d_cyc", i),  32'(obs_q[i].cyc),  32'(exp_q[i].cyc));
      chk($sformatf("ev%0d_wr", i),   32'(obs_q[i].wr),   32'(exp_q[i].wr));
      chk($sformatf("ev%0d_fe", i),   32'(obs_q[i].fe),   32'(exp_q[i].fe));
      chk($sformatf("ev%0d_brk", i),  32'(obs_q[i].brk),  32'(exp_q[i].brk));
      chk($sformatf("ev%0d_data", i), 32'(obs_q[i].data), 32'(exp_q[i].data));
      chk($sformatf("ev%0d_excl", i), 32'(obs_q[i].wr & obs_q[i].fe), 32'd0);
    end
    chk("final_data", 32'(bus.o_data), 32'(last_good));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Serial UART receiver for the 8N1 link that `txuart` drives. It oversamples the incoming line on the system clock, recovers bytes LSB-first, and reports framing errors and line breaks so the echo path can reject corrupted frames. It sits between the `RX` pad and any byte consumer, in place of or next to the plain receiver, and produces the same one-cycle `o_wr` / `o_data` strobe.

## Interface
- `CLOCKS_PER_BAUD`, 24'd1250, system clocks per bit (12 MHz / 9600); legal range is 16 or more.
- `i_clk` in 1 — system clock; all logic is on the rising edge.
- `i_reset` in 1 — reset, synchronous and active-high.
- `i_uart_rx` in 1 — asynchronous serial line; idles high.
- `o_wr` out 1 — one-cycle strobe when a valid byte is received.
- `o_data` out 8 — last valid byte; updated only together with `o_wr`.
- `o_frame_err` out 1 — one-cycle strobe when the stop bit samples low.
- `o_break` out 1 — one-cycle strobe when a framing error has all-zero data; always coincides with `o_frame_err`.

## Operation
- **Input synchronizer:** 2-FF synchronizer on `i_uart_rx`, reset to 1. `rx_s` is the synchronized line.
- **Baud counter:** 24-bit counter. A bit counter runs 0..7.
- **IDLE:** stay here while `rx_s`=1. On `rx_s`=0, load the counter with `CLOCKS_PER_BAUD/2 - 1` (integer divide) and go to START.
- **START:** count down to 0, then sample.
  - `rx_s`=1: false start; return to IDLE with no output.
  - `rx_s`=0: reload the counter with `CLOCKS_PER_BAUD-1`, clear the bit counter, go to DATA.
- **DATA:** at each counter expiry, shift `rx_s` into the MSB of the shift register (so bits come out LSB-first) and reload the counter. After bit 7, go to STOP.
- **STOP:** at counter expiry, sample `rx_s`.
  - Sample = 1: `o_data` <= shift register, `o_wr` <= 1, go to IDLE.
  - Sample = 0: `o_frame_err` <= 1; `o_break` <= 1 if the shift register is 0x00; go to WAIT_HIGH. `o_data` is unchanged.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one error report.
- **Reset values:** `o_wr`, `o_frame_err` and `o_break` = 0; `o_data` = 8'h00; state IDLE; counters 0; synchronizer 1.
- **Reset mid-frame:** abort the frame. No strobe fires, even if the cycle would otherwise have been the stop-sample cycle.

## Timing
- **Cycle t0:** the first cycle in IDLE with `rx_s`=0. `rx_s` lags the pin by 2 cycles.
- **Sample instants**, with H = `CLOCKS_PER_BAUD/2`:
  - start check at t0+H;
  - data bit n (n = 0..7) at t0+H+(n+1)·`CLOCKS_PER_BAUD`;
  - stop bit at t0+H+9·`CLOCKS_PER_BAUD`.
- **Output latency:**
  - `o_wr` / `o_frame_err` / `o_break` are high for exactly one cycle, the cycle after the stop sample.
  - `o_data` is valid in that same cycle and is held until the next `o_wr`.
- **Back-to-back frames:** after a valid stop, the state is IDLE on the strobe cycle. A start edge arriving at t0+10·`CLOCKS_PER_BAUD` (zero idle time) is caught with no byte loss.
- **Exclusivity:** `o_wr` and `o_frame_err` are never high in the same cycle.
- **Tolerance:** baud mismatch up to ±4% must still decode correctly (a mid-bit sample drifts less than half a bit over 9.5 bits).

## Test plan
- **Single byte:** `CLOCKS_PER_BAUD`=16, send 0x55 → exactly one `o_wr` pulse with `o_data`=8'h55, 1 cycle after the stop sample; no error strobes.
- **Back-to-back:** send 0x00 then 0xFF with zero idle → two `o_wr` pulses, `o_data` 8'h00 then 8'hFF, 160 cycles apart.
- **Glitch:** drive the line low for 4 cycles, then high → no strobes; state returns to IDLE; a following 0xA5 decodes as 8'hA5.
- **Framing error:** send 0xA5 with the stop bit low, then idle → one `o_frame_err`, no `o_wr`, no `o_break`, `o_data` keeps its previous value.
- **Break:** hold the line low for 20 bit times, then release, then send 0x3C →
  - exactly one cycle with `o_frame_err`=`o_break`=1;
  - no further strobes while the line is low;
  - then `o_wr` with 8'h3C.
- **Reset mid-frame:** assert `i_reset` for 1 cycle during data bit 4 of 0x81 → no strobe for that frame; outputs are at reset values; the next 0x81 decodes correctly.
